oled_spi_tx: RTL and testbench
==============================

# oled_spi_tx

Byte-level SPI transmitter for the ST7735 OLED/LCD panel. It sits directly downstream of the st7735 command/pixel sequencer. It accepts 8-bit bytes tagged with a data/command flag over a valid/ready handshake and serialises them MSB-first onto `oled_cs`, `oled_clk`, `oled_mosi` and `oled_dc` in SPI mode 0. A one-entry holding register lets the sequencer hand over the next byte while the current one is still shifting.

## Interface
- `C_clk_div`, default 2: SCK half-period in `clk` cycles; legal range ≥1.
- `C_cs_gap`, default 2: `clk` cycles that CS stays high between non-burst bytes; 0 is legal.
- `clk`  in  1: the single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  8: byte to send.
- `in_dc`  in  1: 0 means command byte, 1 means data byte.
- `in_valid`  in  1: byte offered.
- `in_ready`  out  1: holding register empty; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `busy`  out  1: state ≠ IDLE or holding register full.
- `oled_cs`  out  1: chip select, active low.
- `oled_clk`  out  1: SCK, idles low.
- `oled_mosi`  out  1: serial data, MSB first.
- `oled_dc`  out  1: D/C pin; registered copy of the byte's `in_dc`.

## Operation
- Holding register `hold_data`, `hold_dc`, `hold_valid`.
  - `in_ready = !hold_valid && !rst`, combinational.
  - No bypass: a byte always passes through the holding register.
- FSM states: IDLE, SHIFT, GAP.
- IDLE
  - `oled_cs`=1, `oled_clk`=0.
  - If `hold_valid`: load the shift register from `hold_data`, set `oled_dc`←`hold_dc`, `oled_cs`←0, `oled_mosi`←bit7, clear `hold_valid`, go to SHIFT.
- SHIFT
  - Lasts 16·`C_clk_div` cycles: 8 bit-slots, each `C_clk_div` cycles with SCK low followed by `C_clk_div` cycles with SCK high.
  - Panel samples on the rising SCK edge.
  - `oled_mosi` updates to the next bit only when SCK falls, i.e. at the start of each later slot.
  - The bit counter runs 7→0.
- End of SHIFT (SCK back low after bit0): go to GAP with `oled_cs`←1. If `C_cs_gap`=0, go directly to IDLE with `oled_cs`←1.
- GAP
  - `oled_cs`=1, `oled_clk`=0 for `C_cs_gap` cycles, then IDLE.
  - `hold_valid` may be set during GAP; it is consumed on the next IDLE cycle.
- `oled_dc` and `oled_mosi` hold their last values between bytes. `oled_dc` never changes while CS is low.
- `in_data`/`in_dc` are ignored when `in_ready`=0.

## Timing
- Reset values, and the values after any `rst` cycle, including mid-byte:
  - `oled_cs`=1, `oled_clk`=0, `oled_mosi`=0, `oled_dc`=0, `in_ready`=0 during `rst`.
  - `hold_valid`=0 (a held byte is dropped).
  - State = IDLE.
  - `busy`=0.
- The first cycle after `rst` deasserts: `in_ready`=1.
- Byte accepted at edge T with the FSM in IDLE:
  - CS falls at edge T+1.
  - First SCK rise at T+1+`C_clk_div`.
  - CS rises at T+1+16·`C_clk_div`.
- Back-to-back stream, non-burst: one byte every 16·D+G+1 cycles. Defaults give 35.
- `busy` falls on the same edge the FSM re-enters IDLE with `hold_valid`=0.
- `C_clk_div`=1: SCK toggles every cycle, i.e. SCK = `clk`/2.

## Configuration
- `OLED_SPI_BURST_EN` defined:
  - At the end of SHIFT, if `hold_valid`=1, load the next byte on that same edge and stay in SHIFT with CS held low. GAP is skipped.
  - Stream period is 16·`C_clk_div` cycles (32 at the defaults).
  - A change of DC between the two bytes still bursts; `oled_dc` updates at the load edge while SCK is low.
- `OLED_SPI_BURST_EN` undefined: every byte gets its own CS frame and a GAP, exactly as in Operation.

## Structure
- Package `oled_pkg` holds:
  - FSM state enum (IDLE, SHIFT, GAP).
  - Constants `DC_CMD`=0 and `DC_DATA`=1.
  - ST7735 opcode constants shared with the sequencer.
- One sub-module: `oled_spi_tick`, a half-period counter that emits a one-cycle tick every `C_clk_div` cycles. It is cleared on CS assert and on `rst`.

## Test plan
- Reset, then send 0xA5 with dc=0 at default parameters. Required: CS low for exactly 32 cycles; 8 SCK rises; MOSI sampled at the rises = 1,0,1,0,0,1,0,1; `oled_dc`=0 throughout.
- Offer 0x2C/dc=0, 0x12/dc=1 and 0x34/dc=1 with `in_valid` held high, burst disabled. Required: three CS frames of 32 cycles each; CS-high gaps of 3 cycles; `in_ready` low while the holding register is full.
- Same stream with `OLED_SPI_BURST_EN` defined. Required: a single CS-low window of 96 cycles; `oled_dc` goes 0→1 between the first and second byte while SCK is low.
- Assert `rst` for 1 cycle during bit 4 of a byte with a second byte already held. Required: the next cycle shows CS=1, SCK=0, MOSI=0, `busy`=0; the held byte is never transmitted.
- `C_clk_div`=1, `C_cs_gap`=0, send 0xFF. Required: SCK toggles every cycle; CS is low for 16 cycles; the next held byte's CS frame begins after exactly 1 IDLE cycle.
- `in_valid` pulses while `in_ready`=0 with `in_data`=0x00. Required: those bytes are ignored and the transmitted sequence is unchanged.

Source files
------------

// File: rtl/oled_pkg.sv
// oled_pkg: FSM states, D/C codes and ST7735 opcodes shared by the
// SPI transmitter and the st7735 sequencer.
package oled_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_INVOFF  = 8'h20;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;

endpackage

// File: rtl/oled_spi_tick.sv
// oled_spi_tick: one-cycle tick every C_clk_div enabled cycles,
// restarted by clear (CS assert) and rst.
module oled_spi_tick #(
  parameter int C_clk_div = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int W =
    (C_clk_div > 1) ? $clog2(C_clk_div) : 1;
  localparam logic [W-1:0] LAST = W'(C_clk_div - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: ST7735 byte serialiser, SPI mode 0, MSB first.
// Define OLED_SPI_BURST_EN to keep CS low across back-to-back bytes.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int C_clk_div = 2,
  parameter int C_cs_gap  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_dc,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       oled_cs,
  output logic       oled_clk,
  output logic       oled_mosi,
  output logic       oled_dc
);

  localparam int GW =
    (C_cs_gap > 1) ? $clog2(C_cs_gap) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((C_cs_gap > 0) ? C_cs_gap - 1 : 0);

  state_t        state, state_nx;
  logic [7:0]    hold_data;
  logic          hold_dc, hold_valid;
  logic [7:0]    sr, sr_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
  logic          cs_nx, sck_nx, mosi_nx, dc_nx;
  logic          load, tick, burst_ok;

  assign in_ready = !hold_valid && !rst;
  assign busy     = (state != IDLE) || hold_valid;

`ifdef OLED_SPI_BURST_EN
  assign burst_ok = hold_valid;
`else
  assign burst_ok = 1'b0;
`endif

  oled_spi_tick #(.C_clk_div(C_clk_div)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (load),
    .en    (state == SHIFT),
    .tick  (tick)
  );

  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    cs_nx      = oled_cs;
    sck_nx     = oled_clk;
    mosi_nx    = oled_mosi;
    dc_nx      = oled_dc;
    load       = 1'b0;
    unique case (state)
      IDLE: load = hold_valid;
      SHIFT: begin
        if (tick && !oled_clk) begin
          sck_nx = 1'b1;
        end else if (tick) begin
          sck_nx = 1'b0;
          if (bit_cnt != 3'd0) begin
            bit_cnt_nx = bit_cnt - 3'd1;
            sr_nx      = {sr[6:0], 1'b0};
            mosi_nx    = sr[6];
          end else if (burst_ok) begin
            load = 1'b1;
          end else begin
            cs_nx      = 1'b1;
            gap_cnt_nx = '0;
            state_nx   = (C_cs_gap == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Shared by the IDLE start and the burst reload at end of SHIFT.
    if (load) begin
      sr_nx      = hold_data;
      dc_nx      = hold_dc;
      cs_nx      = 1'b0;
      sck_nx     = 1'b0;
      mosi_nx    = hold_data[7];
      bit_cnt_nx = 3'd7;
      state_nx   = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      oled_cs   <= 1'b1;
      oled_clk  <= 1'b0;
      oled_mosi <= 1'b0;
      oled_dc   <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      bit_cnt   <= bit_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      oled_cs   <= cs_nx;
      oled_clk  <= sck_nx;
      oled_mosi <= mosi_nx;
      oled_dc   <= dc_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_dc    <= 1'b0;
    end else if (load) begin
      hold_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
      hold_dc    <= in_dc;
    end
  end

endmodule

// File: tb/tb_oled_spi_tx.sv
// tb_oled_spi_tx: scoreboard bench; an SPI decoder pops expected
// {dc,byte} entries and checks frame and gap timing.
module tb_oled_spi_tx;
  import oled_pkg::*;

  localparam int D     = 2;
  localparam int G     = 2;
  localparam int FRAME = 16 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_dc = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, busy;
  logic       oled_cs, oled_clk, oled_mosi, oled_dc;

  logic [7:0] f_data = '0;
  logic       f_valid = 1'b0;
  logic       f_ready, f_busy;
  logic       f_cs, f_sck, f_mosi, f_dc;

  always #5 clk = ~clk;

  oled_spi_tx #(.C_clk_div(D), .C_cs_gap(G)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dc(in_dc),
    .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .oled_cs(oled_cs),
    .oled_clk(oled_clk), .oled_mosi(oled_mosi),
    .oled_dc(oled_dc)
  );

  oled_spi_tx #(.C_clk_div(1), .C_cs_gap(0)) fdut (
    .clk(clk), .rst(rst),
    .in_data(f_data), .in_dc(1'b1),
    .in_valid(f_valid), .in_ready(f_ready),
    .busy(f_busy), .oled_cs(f_cs),
    .oled_clk(f_sck), .oled_mosi(f_mosi),
    .oled_dc(f_dc)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               name, act, req);
    end
  endtask

  logic [8:0] exp_q[$];
  int flen_q[$], gap_q[$], nbit_q[$];
  logic p_cs = 1'b1, p_sck = 1'b0, p_dc = 1'b0;
  logic abort = 1'b0, have_rise = 1'b0;
  int fstart = 0, rise_t = 0, nbits = 0, fbits = 0;
  logic [7:0] msr = '0;
  logic bdc = 1'b0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (abort || rst) begin
      nbits = 0;
      fbits = 0;
      have_rise = 1'b0;
    end else begin
      if (oled_cs) check("sck_idle_low", oled_clk, 0);
      if (p_cs && !oled_cs) begin
        fstart = cyc;
        fbits  = 0;
        nbits  = 0;
        if (have_rise) gap_q.push_back(cyc - rise_t);
      end
      if (!p_cs && !oled_cs && oled_dc != p_dc) begin
`ifdef OLED_SPI_BURST_EN
        check("dc_change_sck_low_boundary",
              {oled_clk, nbits == 0}, 2'b01);
`else
        check("dc_change_cs_low", oled_dc, p_dc);
`endif
      end
      if (!oled_cs && !p_sck && oled_clk) begin
        msr = {msr[6:0], oled_mosi};
        if (nbits == 0) bdc = oled_dc;
        nbits++;
        fbits++;
        if (nbits == 8) begin
          check("dc_in_byte", oled_dc, bdc);
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_byte: got 0x%0h, want none",
                     {oled_dc, msr});
          end else begin
            e = exp_q.pop_front();
            if ({oled_dc, msr} != e) begin
              errors++;
              $display("FAIL byte: got 0x%0h, want 0x%0h",
                       {oled_dc, msr}, e);
            end
          end
          nbits = 0;
        end
      end
      if (!p_cs && oled_cs) begin
        flen_q.push_back(cyc - fstart);
        nbit_q.push_back(fbits);
        rise_t = cyc;
        have_rise = 1'b1;
        check("partial_byte", nbits, 0);
      end
    end
    p_cs  = oled_cs;
    p_sck = oled_clk;
    p_dc  = oled_dc;
  end

  logic fp_cs = 1'b1, fp_sck = 1'b0, f_have = 1'b0;
  int f_start = 0, f_rise = 0, f_bits = 0;
  logic [7:0] f_sr = '0;
  int f_len_q[$], f_gap_q[$];
  logic [7:0] f_byte_q[$];

  always @(negedge clk) begin
    if (rst) begin
      f_bits = 0;
    end else begin
      if (fp_cs && !f_cs) begin
        f_start = cyc;
        if (f_have) f_gap_q.push_back(cyc - f_rise);
      end else if (!fp_cs && !f_cs) begin
        check("fast_sck_toggle", f_sck, !fp_sck);
      end
      if (!f_cs && !fp_sck && f_sck) begin
        f_sr = {f_sr[6:0], f_mosi};
        f_bits++;
        if (f_bits == 8) begin
          f_byte_q.push_back(f_sr);
          f_bits = 0;
        end
      end
      if (!fp_cs && f_cs) begin
        f_len_q.push_back(cyc - f_start);
        f_rise = cyc;
        f_have = 1'b1;
      end
    end
    fp_cs  = f_cs;
    fp_sck = f_sck;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic d);
    int t = 0;
    in_valid = 1'b1;
    while (!in_ready && t < 500) begin
      in_data = 8'h00;
      in_dc   = 1'($urandom);
      tick(1);
      t++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      in_data = b;
      in_dc   = d;
      exp_q.push_back({d, b});
      tick(1);
      check("in_ready_full", in_ready, 0);
      check("busy_after_accept", busy, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || !oled_cs) && t < 3000) begin
      tick(1);
      t++;
    end
    check("drain_timeout", busy || !oled_cs, 0);
    tick(3);
  endtask

  task automatic clear_log();
    flen_q.delete();
    gap_q.delete();
    nbit_q.delete();
    have_rise = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_cs", oled_cs, 1);
    check("rst_sck", oled_clk, 0);
    check("rst_mosi", oled_mosi, 0);
    check("rst_dc", oled_dc, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);
    tick(1);

    clear_log();
    send(8'hA5, DC_CMD);
    drain();
    check("a5_frames", flen_q.size(), 1);
    if (flen_q.size() == 1) begin
      check("a5_cs_low", flen_q[0], FRAME);
      check("a5_sck_rises", nbit_q[0], 8);
    end

    clear_log();
    send(8'h2C, DC_CMD);
    send(8'h12, DC_DATA);
    send(8'h34, DC_DATA);
    drain();
`ifdef OLED_SPI_BURST_EN
    check("burst_frames", flen_q.size(), 1);
    if (flen_q.size() == 1) begin
      check("burst_cs_low", flen_q[0], 3 * FRAME);
      check("burst_rises", nbit_q[0], 24);
    end
`else
    check("stream_frames", flen_q.size(), 3);
    check("stream_gaps", gap_q.size(), 2);
    foreach (flen_q[i]) check("stream_cs_low", flen_q[i], FRAME);
    foreach (gap_q[i]) check("stream_gap", gap_q[i], G + 1);
`endif

    send(8'h5A, DC_DATA);
    begin
      int t = 0;
      while (oled_cs && t < 100) begin
        tick(1);
        t++;
      end
    end
    check("cs_fall_seen", oled_cs, 0);
    send(8'hC3, DC_CMD);
    tick(12);
    abort = 1'b1;
    rst = 1'b1;
    tick(1);
    check("midrst_cs", oled_cs, 1);
    check("midrst_sck", oled_clk, 0);
    check("midrst_mosi", oled_mosi, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_ready_after", in_ready, 1);
    tick(2);
    abort = 1'b0;
    tick(60);
    check("held_dropped_busy", busy, 0);
    check("held_dropped_cs", oled_cs, 1);
    send(8'h96, DC_DATA);
    drain();

    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 1'($urandom));
      tick($urandom_range(0, 40));
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    f_valid = 1'b1;
    f_data  = 8'hFF;
    tick(1);
    f_data  = 8'h00;
    begin
      int t = 0;
      while (!f_ready && t < 50) begin
        tick(1);
        t++;
      end
    end
    check("fast_ready", f_ready, 1);
    tick(1);
    f_valid = 1'b0;
    tick(60);
    check("fast_frames", f_len_q.size(), 2);
    foreach (f_len_q[i]) check("fast_cs_low", f_len_q[i], 16);
    check("fast_gaps", f_gap_q.size(), 1);
    if (f_gap_q.size() == 1) check("fast_gap", f_gap_q[0], 1);
    check("fast_bytes", f_byte_q.size(), 2);
    if (f_byte_q.size() == 2) begin
      check("fast_byte0", f_byte_q[0], 8'hFF);
      check("fast_byte1", f_byte_q[1], 8'h00);
    end
    check("fast_busy_end", f_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
